mul_operand_sequencer: RTL and testbench
========================================

// Module: mul_operand_sequencer
// PURPOSE
//  Upstream front-end for the repeated-addition multiplier (mul_datapath + mul_control).
//  Accepts an operand pair (A,B) on a valid/ready interface.
//  Serialises the pair onto the multiplier's shared data bus in the order start, A, B.
//  Waits for done, captures the product and presents it on a valid/ready result port.
//  Supervises with a timeout and short-circuits zero operands.
// PARAMETERS
//  W        16    operand/product width (matches multiplier data bus)
//  TIMEOUT  1024  max cycles in WAIT_DONE before error abort; must be >= 2^W/..., >= 4
//  CNT_W    11    timeout counter width, >= clog2(TIMEOUT+1)
// PORTS
//  clk        in   1  clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operand pair valid
//  in_ready   out  1  sequencer can accept a pair (high only in IDLE)
//  in_a       in   W  multiplicand
//  in_b       in   W  multiplier (repeat count)
//  out_valid  out  1  result valid; held until out_ready
//  out_ready  in   1  consumer accepts result
//  out_p      out  W  product, low W bits of A*B
//  out_err    out  1  qualifies out_valid: 1 = timeout abort, out_p = 0
//  mul_start  out  1  start strobe to mul_control
//  mul_data   out  W  drives multiplier data_in
//  mul_done   in   1  done from mul_control (level)
//  mul_y      in   W  product register of mul_datapath
//  busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; out_err=0;
//   out_p=0; mul_start=0; mul_data=0; timeout counter=0. rst wins over every other event.
//  States: IDLE, START, LOAD_A, LOAD_B, WAIT_DONE, HOLD.
//  IDLE: on in_valid&in_ready, register A and B.
//   If A==0 or B==0: go to HOLD with out_p=0, out_err=0. The multiplier is not started.
//   Otherwise: go to START.
//  START (1 cycle): mul_start=1, mul_data=0 -> LOAD_A.
//  LOAD_A (1 cycle): mul_start=0, mul_data=A (cycle mul_control asserts lda) -> LOAD_B.
//  LOAD_B (1 cycle): mul_data=B (ldb cycle) -> WAIT_DONE; counter cleared.
//  WAIT_DONE: mul_data held at B; counter increments each cycle.
//   First cycle with mul_done=1: out_p<=mul_y, out_err<=0 -> HOLD.
//   If counter reaches TIMEOUT-1 without done: out_p<=0, out_err<=1 -> HOLD.
//   mul_done seen in START/LOAD_A/LOAD_B is stale from the previous op and is ignored.
//  HOLD: out_valid=1; out_p/out_err stable. out_valid&out_ready -> IDLE, out_valid=0 next cycle.
//  Latency (nonzero operands): request accept -> START 1 cycle; product visible 1 cycle
//   after first mul_done in WAIT_DONE. Zero short-circuit: out_valid 1 cycle after accept.
//  Width: out_p is mul_y truncated to W; overflow of A*B is not flagged.
//  Only one operation in flight; in_ready=0 from accept until return to IDLE.
//  Same-cycle out_ready and new in_valid in HOLD: the new pair is accepted the following
//   (IDLE) cycle, never in HOLD.
//  rst mid-operation: immediate return to IDLE, result discarded.
//   The multiplier has no reset; the next START re-initialises it.
// STRUCTURE
//  Shared package mul_pkg:
//   - state enum seq_state_t {IDLE,START,LOAD_A,LOAD_B,WAIT_DONE,HOLD}
//   - default W
//   - localparam MUL_LOAD_GAP=1 (cycles start->lda)
//  Single module: FSM + operand/result registers + timeout counter.
//  No sub-module.
//  Bench top instantiates this block + mul_datapath + mul_control.
// TESTING
//  1 rst 2 cycles, then idle 5 cycles -> in_ready=1, out_valid=0, mul_start=0, busy=0.
//  2 A=17,B=5, out_ready=1 -> sequence START/A/B on mul_data; out_p=85, out_err=0.
//    One out_valid pulse.
//  3 A=0,B=9 then A=7,B=0 -> each out_p=0, out_valid 1 cycle after accept, mul_start never 1.
//  4 A=300,B=300 (W=16) -> out_p=90000 mod 65536=24464.
//    out_ready held 0 for 6 cycles -> out_valid, out_p stable throughout.
//  5 Stub mul_done tied 0, TIMEOUT=16 -> out_err=1, out_p=0, in_ready returns after handshake.
//  6 rst asserted during WAIT_DONE of A=9,B=200 -> IDLE next cycle, no out_valid.
//    Next op A=3,B=4 -> out_p=12.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier front-end.
package mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT_DONE,
    HOLD
  } seq_state_t;

  localparam int DEF_W        = 16;
  // Cycles between the start strobe and the multiplier's lda cycle.
  localparam int MUL_LOAD_GAP = 1;

endpackage

// File: rtl/mul_operand_sequencer.sv
// Serialises an (A,B) pair onto the multiplier bus as start/A/B, waits for done
// under a timeout, and returns the product on a valid/ready port; zero operands bypass the multiplier.
module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_y,
  output logic         busy
);

  seq_state_t       state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [CNT_W-1:0] cnt;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_p     <= '0;
      mul_start <= 1'b0;
      mul_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            if (in_a == '0 || in_b == '0) begin
              out_p     <= '0;
              out_err   <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              mul_start <= 1'b1;
              mul_data  <= '0;
              state     <= START;
            end
          end
        end
        START: begin
          mul_start <= 1'b0;
          mul_data  <= a_q;
          state     <= LOAD_A;
        end
        LOAD_A: begin
          mul_data <= b_q;
          state    <= LOAD_B;
        end
        LOAD_B: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Any done seen before this state belongs to the previous operation.
          if (mul_done) begin
            out_p     <= mul_y;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            out_p     <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench: sequencer driving a behavioural repeated-addition multiplier, plus a
// second instance with a dead multiplier and a short timeout.
module tb_mul_operand_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: connected to the behavioural multiplier.
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_err, mul_start, busy;
  logic [W-1:0] out_p, mul_data;
  logic         mul_done = 1'b0;
  logic [W-1:0] mul_y = '0;

  // Instance 1: multiplier that never finishes.
  logic         in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [W-1:0] in_a1 = '0, in_b1 = '0;
  logic         in_ready1, out_valid1, out_err1, mul_start1, busy1;
  logic [W-1:0] out_p1, mul_data1;
  logic         mul_done1 = 1'b0;
  logic [W-1:0] mul_y1 = 16'hBEEF;

  mul_operand_sequencer #(.W(W), .TIMEOUT(1024), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err), .mul_start(mul_start), .mul_data(mul_data),
    .mul_done(mul_done), .mul_y(mul_y), .busy(busy)
  );

  mul_operand_sequencer #(.W(W), .TIMEOUT(16), .CNT_W(5)) dut_to (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_p(out_p1), .out_err(out_err1), .mul_start(mul_start1), .mul_data(mul_data1),
    .mul_done(mul_done1), .mul_y(mul_y1), .busy(busy1)
  );

  // Behavioural multiplier: start clears, next cycle loads A, next loads B,
  // then adds A once per cycle B times and raises done (level) until the next start.
  logic [1:0]   sph = 2'd0;
  logic [W-1:0] sa = '0, scnt = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      sph <= 2'd1; mul_done <= 1'b0; mul_y <= '0;
    end else begin
      case (sph)
        2'd1: begin sa <= mul_data; sph <= 2'd2; end
        2'd2: begin scnt <= mul_data; sph <= 2'd3; end
        2'd3: if (scnt == 0) mul_done <= 1'b1;
              else begin mul_y <= mul_y + sa; scnt <= scnt - 1'b1; end
        default: ;
      endcase
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: one result per accepted pair, low W bits of A*B, never an error
  // on instance 0 (its multiplier always completes well inside the timeout).
  logic [W:0]   exp_q[$];
  logic [W:0]   front;
  logic         inflight = 1'b0;
  logic         held = 1'b0;
  logic [W-1:0] held_p = '0;
  logic [W-1:0] cur_a = '0, cur_b = '0;
  int           seq_ph = 0;
  int           start_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      inflight = 1'b0;
      held     = 1'b0;
      seq_ph   = 0;
    end else begin
      check("in_ready_vs_inflight", {31'd0, in_ready}, {31'd0, !inflight});
      if (held) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_p", {16'd0, out_p}, {16'd0, held_p});
      end
      if (mul_start) begin
        start_cnt++;
        check("start_data", {16'd0, mul_data}, 32'd0);
        seq_ph = 1;
      end else if (seq_ph == 1) begin
        check("lda_data", {16'd0, mul_data}, {16'd0, cur_a});
        seq_ph = 2;
      end else if (seq_ph == 2) begin
        check("ldb_data", {16'd0, mul_data}, {16'd0, cur_b});
        seq_ph = 0;
      end
      held = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_ready) begin
          front = exp_q.pop_front();
          check("result_p", {16'd0, out_p}, {16'd0, front[W-1:0]});
          check("result_err", {31'd0, out_err}, {31'd0, front[W]});
        end else begin
          held   = 1'b1;
          held_p = exp_q[0][W-1:0];
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, W'(32'(in_a) * 32'(in_b))});
        cur_a    = in_a;
        cur_b    = in_b;
        inflight = 1'b1;
      end
      if (out_valid && out_ready) inflight = 1'b0;
    end
  end

  task automatic send0(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1; in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1; in_valid = 1'b0;
  endtask

  task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1; in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
    @(posedge clk); #1; in_valid1 = 1'b0;
  endtask

  task automatic wait_valid0(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < budget) begin @(negedge clk); k++; end
    if (!out_valid) check({name, "_timeout"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int k;
    int seen;
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mul_start", {31'd0, mul_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_p", {16'd0, out_p}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_mul_data", {16'd0, mul_data}, 32'd0);
    check("rst_in_ready1", {31'd0, in_ready1}, 32'd1);

    // 2: 17*5, product one cycle after the first done, single valid pulse
    out_ready = 1'b1;
    send0(16'd17, 16'd5);
    k = 0;
    @(negedge clk);
    while (!mul_done && k < 60) begin @(negedge clk); k++; end
    check("t2_done_seen", {31'd0, mul_done}, 32'd1);
    check("t2_valid_before", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_p", {16'd0, out_p}, 32'd85);
    check("t2_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    check("t2_pulse_end", {31'd0, out_valid}, 32'd0);

    // 3: zero operands short-circuit
    send0(16'd0, 16'd9);
    @(negedge clk);
    check("t3a_valid", {31'd0, out_valid}, 32'd1);
    check("t3a_p", {16'd0, out_p}, 32'd0);
    send0(16'd7, 16'd0);
    @(negedge clk);
    check("t3b_valid", {31'd0, out_valid}, 32'd1);
    check("t3b_p", {16'd0, out_p}, 32'd0);
    check("t3b_err", {31'd0, out_err}, 32'd0);

    // 4: truncated product held under backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    send0(16'd300, 16'd300);
    wait_valid0("t4", 400);
    check("t4_p", {16'd0, out_p}, 32'd24464);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_p", {16'd0, out_p}, 32'd24464);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_released", {31'd0, out_valid}, 32'd0);

    // 5: timeout abort on the dead multiplier (TIMEOUT=16)
    send1(16'd5, 16'd7);
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid1 && k < 100);
    check("t5_latency", k, 32'd20);
    check("t5_err", {31'd0, out_err1}, 32'd1);
    check("t5_p", {16'd0, out_p1}, 32'd0);
    check("t5_in_ready_low", {31'd0, in_ready1}, 32'd0);
    @(posedge clk); #1 out_ready1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_ready_back", {31'd0, in_ready1}, 32'd1);
    check("t5_valid_clear", {31'd0, out_valid1}, 32'd0);

    // 6: reset during WAIT_DONE discards the result, next op is clean
    send0(16'd9, 16'd200);
    repeat (10) @(negedge clk);
    check("t6_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    check("t6_idle_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("t6_no_valid", seen, 32'd0);
    send0(16'd3, 16'd4);
    wait_valid0("t6b", 60);
    check("t6b_p", {16'd0, out_p}, 32'd12);
    @(negedge clk);

    // Only the four nonzero pairs may have started the multiplier.
    check("start_count", start_cnt, 32'd4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
